// File: rtl/nn_pkg.sv
// Shared types for the classifier datapath: scan FSM states and the default signed element type.
package nn_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  localparam int DATA_W = 16;
  typedef logic signed [DATA_W-1:0] data_t;
endpackage

// File: rtl/argmax_finder.sv
// Output classifier: latches a vector of signed neuron outputs and scans it one element per cycle,
// reporting the index/value of the largest entry (lowest index on ties).
import nn_pkg::*;

module argmax_finder #(
  parameter int numInputs  = 10,
  parameter int dataWidth  = 16,
  parameter int indexWidth = $clog2(numInputs)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [dataWidth*numInputs-1:0]  dataIn,
  input  logic                            inValid,
  output logic                            busy,
  output logic [indexWidth-1:0]           maxIndex,
  output logic [dataWidth-1:0]            maxValue,
  output logic                            outValid
);
  localparam logic [indexWidth-1:0] LAST_IDX = indexWidth'(numInputs - 1);

  state_t                              state_q;
  logic [numInputs-1:0][dataWidth-1:0] cap_q;
  logic [indexWidth-1:0]               idx_q;
  logic [indexWidth-1:0]               run_idx_q;
  logic signed [dataWidth-1:0]         run_max_q;
  logic signed [dataWidth-1:0]         cand_d;

  assign cand_d = cap_q[idx_q];
  assign busy   = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cap_q     <= '0;
      idx_q     <= '0;
      run_idx_q <= '0;
      run_max_q <= '0;
      maxIndex  <= '0;
      maxValue  <= '0;
      outValid  <= 1'b0;
    end else begin
      outValid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (inValid) begin
            cap_q     <= dataIn;
            run_max_q <= dataIn[dataWidth-1:0];
            run_idx_q <= '0;
            idx_q     <= indexWidth'(1);
            state_q   <= SCAN;
          end
        end
        SCAN: begin
          // Strict compare keeps the earliest index on ties.
          if (cand_d > run_max_q) begin
            run_max_q <= cand_d;
            run_idx_q <= idx_q;
          end
          if (idx_q == LAST_IDX) state_q <= DONE;
          else                   idx_q   <= idx_q + 1'b1;
        end
        DONE: begin
          maxIndex <= run_idx_q;
          maxValue <= run_max_q;
          outValid <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_argmax_finder.sv
// Self-checking bench for argmax_finder: directed table, hand sequences for busy/reset corners,
// and random vectors against a max-then-first-index reference.
module tb_argmax_finder;
  localparam int N  = 10;
  localparam int W  = 16;
  localparam int IW = 4;

  typedef logic [N-1:0][W-1:0] vec_t;
  typedef struct {
    string        name;
    vec_t         v;
    int           exp_idx;
    logic [W-1:0] exp_val;
  } rec_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           inValid;
  logic [N*W-1:0] dataIn;
  logic           busy;
  logic [IW-1:0]  maxIndex;
  logic [W-1:0]   maxValue;
  logic           outValid;

  int checks = 0;
  int failures = 0;

  argmax_finder #(.numInputs(N), .dataWidth(W)) dut (
    .clk(clk), .reset(reset), .dataIn(dataIn), .inValid(inValid),
    .busy(busy), .maxIndex(maxIndex), .maxValue(maxValue), .outValid(outValid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: find the largest signed value, then the first index holding it.
  task automatic ref_argmax(input vec_t v, output int idx, output logic [W-1:0] val);
    int mx, e;
    mx = -(1 << (W - 1));
    for (int i = 0; i < N; i++) begin
      e = $signed(v[i]);
      if (e > mx) mx = e;
    end
    idx = -1;
    for (int i = N - 1; i >= 0; i--) begin
      e = $signed(v[i]);
      if (e == mx) idx = i;
    end
    val = mx[W-1:0];
  endtask

  // Presents v for one edge; afterwards dataIn is overwritten to prove the capture is latched.
  task automatic accept(input vec_t v);
    @(negedge clk);
    dataIn  = v;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    dataIn  = {N{16'h7FFF}};
  endtask

  task automatic wait_out(output int lat, output int nb);
    lat = -1;
    nb  = int'(busy);
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk);
      #1;
      if (outValid) begin
        lat = j;
        break;
      end
      nb += int'(busy);
    end
  endtask

  task automatic run_check(input string nm, input vec_t v, input int ei, input logic [W-1:0] ev);
    int lat, nb;
    accept(v);
    wait_out(lat, nb);
    chk({nm, " latency"}, lat, N);
    chk({nm, " busy_cycles"}, nb, N);
    chk({nm, " maxIndex"}, {28'd0, maxIndex}, ei);
    chk({nm, " maxValue"}, {16'd0, maxValue}, {16'd0, ev});
    @(posedge clk);
    #1;
    chk({nm, " outValid_drop"}, {31'd0, outValid}, 0);
  endtask

  rec_t tbl[5];

  initial begin
    int lat, nb, ov, ri;
    logic [W-1:0] rv;
    vec_t va, vb, vr;

    tbl[0] = '{"basic",
      {16'h0001, 16'h0000, 16'h0000, 16'h0300, 16'h0080, 16'h0000, 16'h0200, 16'hFC00, 16'h0400, 16'h0100},
      1, 16'h0400};
    tbl[1] = '{"all_negative",
      {16'hF800, 16'hF800, 16'hFE00, 16'hF800, 16'hF800, 16'hF800, 16'hF800, 16'hF800, 16'hF800, 16'hFC00},
      7, 16'hFE00};
    tbl[2] = '{"tie",
      {16'h0100, 16'h0500, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0500, 16'h0100, 16'h0100, 16'h0100},
      3, 16'h0500};
    tbl[3] = '{"all_min", {N{16'h8000}}, 0, 16'h8000};
    tbl[4] = '{"max_last", {16'h7FFF, {(N-1){16'h8000}}}, 9, 16'h7FFF};

    reset = 1'b1; inValid = 1'b0; dataIn = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset outValid", {31'd0, outValid}, 0);
    chk("reset maxIndex", {28'd0, maxIndex}, 0);
    chk("reset maxValue", {16'd0, maxValue}, 0);

    foreach (tbl[i]) run_check(tbl[i].name, tbl[i].v, tbl[i].exp_idx, tbl[i].exp_val);

    // Second request mid-scan is dropped; one in the outValid cycle is accepted.
    va = tbl[0].v;
    vb = tbl[1].v;
    accept(va);
    repeat (3) @(posedge clk);
    #1;
    dataIn = vb; inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0; dataIn = {N{16'h7FFF}};
    wait_out(lat, nb);
    chk("ignored latency", lat, N - 4);
    chk("ignored maxIndex", {28'd0, maxIndex}, 1);
    chk("ignored maxValue", {16'd0, maxValue}, 32'h0400);
    dataIn = vb; inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0; dataIn = {N{16'h7FFF}};
    wait_out(lat, nb);
    chk("b2b latency", lat, N);
    chk("b2b maxIndex", {28'd0, maxIndex}, 7);
    chk("b2b maxValue", {16'd0, maxValue}, 32'hFE00);

    // Reset at edge k+5 aborts the scan and clears the outputs.
    accept(tbl[2].v);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midreset busy", {31'd0, busy}, 0);
    chk("midreset maxIndex", {28'd0, maxIndex}, 0);
    chk("midreset maxValue", {16'd0, maxValue}, 0);
    ov = 0;
    for (int j = 0; j < 15; j++) begin
      @(posedge clk);
      #1;
      ov += int'(outValid);
    end
    chk("midreset no_outValid", ov, 0);

    // inValid coincident with reset must not start a scan.
    @(negedge clk);
    reset = 1'b1; inValid = 1'b1; dataIn = tbl[4].v;
    @(posedge clk);
    #1;
    reset = 1'b0; inValid = 1'b0;
    chk("reset_wins busy", {31'd0, busy}, 0);
    ov = 0;
    for (int j = 0; j < 15; j++) begin
      @(posedge clk);
      #1;
      ov += int'(outValid);
    end
    chk("reset_wins no_outValid", ov, 0);

    run_check("after_reset", tbl[0].v, 1, 16'h0400);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: vr[i] = W'($urandom);
          1: vr[i] = 16'h7FFF;
          2: vr[i] = 16'h8000;
          default: vr[i] = W'($urandom_range(0, 3)) - 16'd1;
        endcase
      end
      ref_argmax(vr, ri, rv);
      run_check($sformatf("rand%0d", t), vr, ri, rv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/argmax_finder.md
Name: argmax_finder

Overview:
- Output classifier stage. Sits directly downstream of the final fully-connected layer and consumes its flat `layerOut` vector and `layerOutValid`.
- Scans the numInputs signed fixed-point neuron outputs sequentially, one comparison per cycle, and reports the index and value of the largest entry, i.e. the predicted class.
- Latches its input on acceptance, so the upstream layer may change its output immediately afterwards.

Parameters:
- numInputs, 10, number of neuron outputs to compare; must be >= 2.
- dataWidth, 16, width of each element, signed two's complement (Q6.10 by default; the format is irrelevant to the comparison).
- indexWidth, $clog2(numInputs), width of the reported index.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- dataIn  input  dataWidth*numInputs  flat vector; element i occupies bits [(i+1)*dataWidth-1 -: dataWidth].
- inValid  input  1  dataIn is valid; single-cycle pulse or level.
- busy  output  1  high while a scan is in progress; inValid is ignored while busy.
- maxIndex  output  indexWidth  index of the largest element of the last completed scan.
- maxValue  output  dataWidth  value of that element.
- outValid  output  1  one-cycle pulse: maxIndex/maxValue were updated this cycle.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: busy=0, maxIndex=0, maxValue=0, outValid=0, state=IDLE, internal capture register=0, scan counter=0.
- States: IDLE, SCAN, DONE.
- IDLE: if inValid=1 at edge k:
  - capture all of dataIn into the internal register;
  - runningMax <= element 0, runningIdx <= 0, idx <= 1;
  - go to SCAN.
- SCAN: each edge compares captured[idx] against runningMax as signed values.
  - If strictly greater, update runningMax and runningIdx.
  - idx increments by 1.
  - On the edge that processes idx == numInputs-1, go to DONE. idx does not wrap past numInputs-1.
- DONE, at edge k+numInputs:
  - maxIndex <= runningIdx, maxValue <= runningMax, outValid <= 1;
  - go to IDLE.
- outValid is high for exactly one cycle, following edge k+numInputs. Latency from accepting edge to outValid is numInputs cycles.
- maxIndex/maxValue hold their values until the next completed scan. They are never changed mid-scan.
- busy=1 whenever state is SCAN or DONE, as a combinational decode of state.
  - inValid with busy=1 is dropped, with no queueing.
  - The upstream stage must hold or re-present its data.
- Back-to-back: inValid asserted during the outValid cycle (state IDLE) is accepted. Peak throughput is one result per numInputs+1 cycles.
- Ties: the lowest index wins, because the compare is strict.
- Comparison is full-width signed. Example: 0x8000 (most negative) never beats any other value; 0x7FFF beats everything.
- Reset mid-scan:
  - aborts immediately and returns to IDLE;
  - no outValid pulse;
  - outputs go to their reset values.
- inValid asserted together with reset: reset wins and the data is not captured.

Decomposition:
- Shared package nn_pkg:
  - state enum {IDLE, SCAN, DONE};
  - signed data typedef of dataWidth.
- No sub-module. The comparator is one signed `>` inline.
- Capture register plus idx mux, roughly 150 lines.

Test Plan:
- numInputs=10, dataIn = {0x0100, 0x0400, 0xFC00, 0x0200, 0x0000, 0x0080, 0x0300, 0x0000, 0x0000, 0x0001} (element 0 first), inValid pulse at edge k -> outValid at edge k+10 only, maxIndex=1, maxValue=0x0400, busy high for 10 cycles.
- All elements negative: element 0 = 0xFC00, others 0xF800, except element 7 = 0xFE00 -> maxIndex=7, maxValue=0xFE00. Verifies the signed compare.
- Ties: elements 3 and 8 both 0x0500, all others 0x0100 -> maxIndex=3.
- Second inValid at k+4 with different data -> ignored; result reflects the first vector only. Then inValid during the outValid cycle -> accepted, second outValid at 10 cycles later.
- dataIn changes to all-0x7FFF one cycle after capture -> result unchanged from the captured data.
- reset asserted at edge k+5 of a scan -> no outValid, maxIndex=0, maxValue=0, busy=0 next cycle. A new scan started afterwards completes normally.
